// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Definitions shared by the processing-element controller and the PE array:
//   - pe_state_e   : controller state encoding (IDLE, COMP, OUPT)
//   - PE_* consts  : default element width and row/filter/output sizes
//   - pe_acc_width : accumulator width for a given element width
// ---------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        OUPT = 2'd2
    } pe_state_e;

    localparam int PE_INWIDTH = 16;
    localparam int PE_FIL_S   = 3;
    localparam int PE_DI_W    = 7;
    localparam int PE_DO_W    = PE_DI_W - PE_FIL_S + 1;

    // Products are 2*inwidth wide; two guard bits absorb the tap sum and psum add.
    function automatic int pe_acc_width(input int inwidth);
        return 2 * inwidth + 2;
    endfunction

endpackage

// File: rtl/pe_mac3.sv
// ---------------------------------------------------------------------------
// pe_mac3
// Combinational FIL_S-tap multiply-accumulate for one output window:
//   acc = psum + sum_k filter[k] * window[k]   (all operands signed)
// Ports:
//   filter  in  FIL_S*INWIDTH  taps, tap k at [k*INWIDTH +: INWIDTH]
//   window  in  FIL_S*INWIDTH  data elements aligned with the taps
//   psum    in  INWIDTH        incoming partial sum for this window
//   acc     out AW             full-precision signed result
// ---------------------------------------------------------------------------
module pe_mac3
    import pe_pkg::*;
#(
    parameter int INWIDTH = PE_INWIDTH,
    parameter int FIL_S   = PE_FIL_S,
    parameter int AW      = pe_acc_width(PE_INWIDTH)
) (
    input  logic [FIL_S*INWIDTH-1:0] filter,
    input  logic [FIL_S*INWIDTH-1:0] window,
    input  logic [INWIDTH-1:0]       psum,
    output logic [AW-1:0]            acc
);

    localparam int PW = 2 * INWIDTH;

    logic signed [PW-1:0] prod_s [FIL_S];
    logic signed [AW-1:0] sum_s;

    // Per-tap signed products; operands are sign-extended before multiplying.
    always_comb begin
        for (int k = 0; k < FIL_S; k++) begin
            prod_s[k] = PW'($signed(filter[k*INWIDTH +: INWIDTH]))
                      * PW'($signed(window[k*INWIDTH +: INWIDTH]));
        end
    end

    // Accumulate products on top of the incoming partial sum.
    always_comb begin
        sum_s = AW'($signed(psum));
        for (int k = 0; k < FIL_S; k++) begin
            sum_s = sum_s + AW'(prod_s[k]);
        end
    end

    assign acc = sum_s;

endmodule

// File: rtl/pe_ctrl.sv
// ---------------------------------------------------------------------------
// pe_ctrl
// Row-convolution PE controller. Accepts one job (filter row, data row and
// incoming partial sums), evaluates one output window per enabled cycle on a
// single shared pe_mac3, then presents the partial sums until consumed.
//
// Optional build macro:
//   PE_CTRL_SAT_EN  defined   -> results saturate to the signed INWIDTH range
//                   undefined -> results wrap (low INWIDTH bits kept)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   en         in   global enable, 0 freezes all state and blocks handshakes
//   in_valid   in   filter_in/data_in/psum_in valid
//   in_ready   out  new job accepted (IDLE and enabled)
//   filter_in  in   FIL_S*INWIDTH, tap k at [k*INWIDTH +: INWIDTH]
//   data_in    in   DI_W*INWIDTH,  element i at [i*INWIDTH +: INWIDTH]
//   psum_in    in   DO_W*INWIDTH,  incoming partial sums
//   out_valid  out  psum_out valid (OUPT and enabled)
//   out_ready  in   consumer accepts psum_out
//   psum_out   out  DO_W*INWIDTH result partial sums, zero outside OUPT
//   busy       out  job in progress (COMP or OUPT)
//   done       out  one-cycle pulse after the output handshake
// ---------------------------------------------------------------------------
module pe_ctrl
    import pe_pkg::*;
#(
    parameter int INWIDTH = PE_INWIDTH,
    parameter int FIL_S   = PE_FIL_S,
    parameter int DI_W    = PE_DI_W,
    parameter int DO_W    = PE_DO_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FIL_S*INWIDTH-1:0] filter_in,
    input  logic [DI_W*INWIDTH-1:0]  data_in,
    input  logic [DO_W*INWIDTH-1:0]  psum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DO_W*INWIDTH-1:0]  psum_out,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = pe_acc_width(INWIDTH);
    localparam int CW = (DO_W > 1) ? $clog2(DO_W) : 1;
    localparam logic [CW-1:0] LAST_WIN = CW'(DO_W - 1);

    if (DO_W != DI_W - FIL_S + 1) begin : g_do_w_check
        $error("pe_ctrl: DO_W must equal DI_W - FIL_S + 1");
    end

`ifdef PE_CTRL_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX =
        $signed({{(AW-INWIDTH+1){1'b0}}, {(INWIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN =
        $signed({{(AW-INWIDTH+1){1'b1}}, {(INWIDTH-1){1'b0}}});
`endif

    // Narrow a full-precision accumulator to one INWIDTH result element.
    function automatic logic [INWIDTH-1:0] reduce_acc(input logic signed [AW-1:0] acc);
`ifdef PE_CTRL_SAT_EN
        if (acc > SAT_MAX) begin
            reduce_acc = INWIDTH'(SAT_MAX);
        end else if (acc < SAT_MIN) begin
            reduce_acc = INWIDTH'(SAT_MIN);
        end else begin
            reduce_acc = INWIDTH'(acc);
        end
`else
        reduce_acc = INWIDTH'(acc);
`endif
    endfunction

    pe_state_e                  state_r;
    pe_state_e                  next_state_s;
    logic [CW-1:0]              counter_r;
    logic [FIL_S*INWIDTH-1:0]   filter_r;
    logic [DI_W*INWIDTH-1:0]    data_r;
    logic [DO_W*INWIDTH-1:0]    psum_r;
    logic [DO_W*INWIDTH-1:0]    res_r;
    logic                       done_r;

    logic                       load_s;
    logic                       step_s;
    logic                       done_set_s;
    logic                       in_ready_s;
    logic                       out_valid_s;
    logic [FIL_S*INWIDTH-1:0]   win_s;
    logic [INWIDTH-1:0]         psum_sel_s;
    logic [AW-1:0]              acc_s;
    logic [INWIDTH-1:0]         red_s;

    // Next-state decode plus the load/step/done strobes that drive the datapath.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        done_set_s   = 1'b0;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = en;
                if (en && in_valid) begin
                    load_s       = 1'b1;
                    next_state_s = COMP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COMP: begin
                if (en) begin
                    step_s = 1'b1;
                    if (counter_r == LAST_WIN) begin
                        next_state_s = OUPT;
                    end else begin
                        next_state_s = COMP;
                    end
                end else begin
                    next_state_s = COMP;
                end
            end
            OUPT: begin
                out_valid_s = en;
                if (en && out_ready) begin
                    done_set_s   = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUPT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; a disabled cycle holds the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (en) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // The window slides one element per step, so window i starts at data element i.
    always_comb begin
        win_s      = data_r[int'(counter_r)*INWIDTH +: FIL_S*INWIDTH];
        psum_sel_s = psum_r[int'(counter_r)*INWIDTH +: INWIDTH];
    end

    pe_mac3 #(
        .INWIDTH (INWIDTH),
        .FIL_S   (FIL_S),
        .AW      (AW)
    ) u_mac (
        .filter  (filter_r),
        .window  (win_s),
        .psum    (psum_sel_s),
        .acc     (acc_s)
    );

    assign red_s = reduce_acc(acc_s);

    // Job operand capture, window counter and per-window result slots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filter_r  <= {(FIL_S*INWIDTH){1'b0}};
            data_r    <= {(DI_W*INWIDTH){1'b0}};
            psum_r    <= {(DO_W*INWIDTH){1'b0}};
            res_r     <= {(DO_W*INWIDTH){1'b0}};
            counter_r <= {CW{1'b0}};
        end else if (load_s) begin
            filter_r  <= filter_in;
            data_r    <= data_in;
            psum_r    <= psum_in;
            res_r     <= {(DO_W*INWIDTH){1'b0}};
            counter_r <= {CW{1'b0}};
        end else if (step_s) begin
            res_r[int'(counter_r)*INWIDTH +: INWIDTH] <= red_s;
            // Wrap back to 0 so the window select never runs past the data row.
            counter_r <= (counter_r == LAST_WIN) ? {CW{1'b0}} : counter_r + CW'(1);
        end else begin
            filter_r  <= filter_r;
            data_r    <= data_r;
            psum_r    <= psum_r;
            res_r     <= res_r;
            counter_r <= counter_r;
        end
    end

    // Completion pulse, raised for exactly the cycle after the output handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_set_s;
        end
    end

    // Handshake outputs also drop while reset is asserted.
    assign in_ready  = in_ready_s & rst;
    assign out_valid = out_valid_s & rst;
    assign busy      = (state_r != IDLE);
    assign psum_out  = (state_r == OUPT) ? res_r : {(DO_W*INWIDTH){1'b0}};
    assign done      = done_r;

endmodule

// File: tb/tb_pe_ctrl.sv
module tb_pe_ctrl;

    localparam int W  = 16;
    localparam int FS = 3;
    localparam int DI = 7;
    localparam int DO = 5;
    localparam int FW = FS * W;
    localparam int DW = DI * W;
    localparam int PW = DO * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [FW-1:0] filter_in = '0;
    logic [DW-1:0] data_in = '0;
    logic [PW-1:0] psum_in = '0;
    logic          in_ready, out_valid, busy, done;
    logic [PW-1:0] psum_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pe_ctrl #(.INWIDTH(W), .FIL_S(FS), .DI_W(DI), .DO_W(DO)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .filter_in(filter_in), .data_in(data_in), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out),
        .busy(busy), .done(done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [PW-1:0] ref_job(input logic [FW-1:0] f, input logic [DW-1:0] d,
                                              input logic [PW-1:0] p);
        logic [PW-1:0] r;
        longint acc;
        logic [63:0] a64;
        r = '0;
        for (int i = 0; i < DO; i++) begin
            acc = longint'($signed(p[i*W +: W]));
            for (int k = 0; k < FS; k++)
                acc += longint'($signed(f[k*W +: W])) * longint'($signed(d[(i+k)*W +: W]));
`ifdef PE_CTRL_SAT_EN
            if (acc > 64'sd32767) acc = 64'sd32767;
            else if (acc < -64'sd32768) acc = -64'sd32768;
`endif
            a64 = acc;
            r[i*W +: W] = a64[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [127:0] pack7(input int a0, a1, a2, a3, a4, a5, a6);
        int v[7];
        logic [127:0] r;
        logic [31:0] t;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4; v[5] = a5; v[6] = a6;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            t = v[i];
            r[i*W +: W] = t[W-1:0];
        end
        return r;
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk1(input string nm, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic chkv(input string nm, input logic [127:0] a, input logic [127:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // ph: 0 waiting for a job, 1 computing (left = enabled cycles remaining), 2 presenting
    int            ph = 0;
    int            left = 0;
    int            jobs_done = 0;
    bit            done_m = 1'b0;
    bit            chk_on = 1'b0;
    logic [PW-1:0] res_m = '0;

    always @(posedge clk) begin
        int nph, nleft, nj;
        bit ndn;
        logic [PW-1:0] nres;
        nph = ph; nleft = left; nj = jobs_done; ndn = 1'b0; nres = res_m;
        if (!rst) begin
            nph = 0; nleft = 0;
        end else if (ph == 0) begin
            if (en && in_valid) begin
                nres = ref_job(filter_in, data_in, psum_in);
                nph = 1; nleft = DO;
            end
        end else if (ph == 1) begin
            if (en) begin
                nleft = left - 1;
                if (nleft == 0) nph = 2;
            end
        end else begin
            if (en && out_ready) begin
                nph = 0; ndn = 1'b1; nj = jobs_done + 1;
            end
        end
        ph <= nph; left <= nleft; done_m <= ndn; res_m <= nres; jobs_done <= nj;
        if (!rst) chk_on <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk1("in_ready", in_ready, rst && en && (ph == 0));
            chk1("out_valid", out_valid, rst && en && (ph == 2));
            chk1("busy", busy, ph != 0);
            chk1("done", done, done_m);
            chkv("psum_out", 128'(psum_out), (ph == 2) ? 128'(res_m) : 128'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_elem();
        case ($urandom_range(0, 4))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return W'($urandom_range(0, 9));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic scramble();
        for (int k = 0; k < FS; k++) filter_in[k*W +: W] = rnd_elem();
        for (int k = 0; k < DI; k++) data_in[k*W +: W] = rnd_elem();
        for (int k = 0; k < DO; k++) psum_in[k*W +: W] = rnd_elem();
    endtask

    task automatic run_job(input string nm, input logic [FW-1:0] f, input logic [DW-1:0] d,
                           input logic [PW-1:0] p, input logic [PW-1:0] exp_res,
                           input int exp_lat, input int ready_hold, input bit en_gap);
        int t0, n;
        filter_in = f; data_in = d; psum_in = p; in_valid = 1'b1;
        out_ready = (ready_hold == 0);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk1({nm, "_accept"}, in_ready, 1'b1);
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        scramble();
        if (en_gap) begin
            tick(); en = 1'b0;
            repeat (3) tick();
            en = 1'b1;
        end
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk1({nm, "_out_valid"}, out_valid, 1'b1);
        chki({nm, "_latency"}, cyc - t0, exp_lat);
        chkv({nm, "_result"}, 128'(psum_out), 128'(exp_res));
        for (int j = 0; j < ready_hold; j++) begin
            chkv({nm, "_hold_result"}, 128'(psum_out), 128'(exp_res));
            chk1({nm, "_hold_in_ready"}, in_ready, 1'b0);
            chk1({nm, "_hold_done"}, done, 1'b0);
            tick();
            if (j == ready_hold - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        chk1({nm, "_handshake_valid"}, out_valid, 1'b1);
        @(negedge clk);
        chk1({nm, "_done_pulse"}, done, 1'b1);
        chk1({nm, "_busy_after"}, busy, 1'b0);
        chkv({nm, "_psum_idle"}, 128'(psum_out), 128'd0);
        @(negedge clk);
        chk1({nm, "_done_single"}, done, 1'b0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    logic [FW-1:0] fa, fmax;
    logic [DW-1:0] da, dmax;
    logic [PW-1:0] p0, p100, exp_a, exp_b, exp_max;

    initial begin
        int n, t0;
        fa    = FW'(pack7(1, 2, 3, 0, 0, 0, 0));
        da    = DW'(pack7(1, 2, 3, 4, 5, 6, 7));
        p0    = '0;
        p100  = PW'(pack7(100, 100, 100, 100, 100, 0, 0));
        exp_a = PW'(pack7(14, 20, 26, 32, 38, 0, 0));
        exp_b = PW'(pack7(114, 120, 126, 132, 138, 0, 0));
        fmax  = FW'(pack7(32767, 32767, 32767, 0, 0, 0, 0));
        dmax  = DW'(pack7(32767, 32767, 32767, 32767, 32767, 32767, 32767));
`ifdef PE_CTRL_SAT_EN
        exp_max = PW'(pack7(32767, 32767, 32767, 32767, 32767, 0, 0));
`else
        exp_max = PW'(pack7(3, 3, 3, 3, 3, 0, 0));
`endif
        // Hand-computed values pin the reference model itself.
        chkv("model_pin_a", 128'(ref_job(fa, da, p0)), 128'(exp_a));
        chkv("model_pin_b", 128'(ref_job(fa, da, p100)), 128'(exp_b));
        chkv("model_pin_max", 128'(ref_job(fmax, dmax, p0)), 128'(exp_max));

        rst = 1'b0; en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk1("reset_in_ready", in_ready, 1'b0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chkv("reset_psum_out", 128'(psum_out), 128'd0);
        tick();
        rst = 1'b1;

        run_job("job_a", fa, da, p0, exp_a, DO + 1, 0, 1'b0);
        run_job("job_b", fa, da, p100, exp_b, DO + 1, 0, 1'b0);
        run_job("stall_ready", fa, da, p0, exp_a, DO + 1, 10, 1'b0);
        run_job("extreme", fmax, dmax, p0, exp_max, DO + 1, 0, 1'b0);
        run_job("en_gap", fa, da, p100, exp_b, DO + 4, 0, 1'b1);

        // Reset while computing window 2 abandons the job.
        filter_in = fa; data_in = da; psum_in = p0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk1("midrst_accept", in_ready, 1'b1);
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chki("midrst_cycle", cyc - t0, 3);
        chk1("midrst_busy_before", busy, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst_busy_after", busy, 1'b0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        tick();
        run_job("after_rst", fa, da, p0, exp_a, DO + 1, 0, 1'b0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            scramble();
            tick();
        end
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) tick();
        chk1("random_jobs_seen", jobs_done > 20, 1'b1);
        chk1("drain_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
